// File: rtl/biquad_pkg.sv
// Shared constants and types for the biquad zero (numerator) FIR section:
// coefficient format, reset coefficient values and the coefficient-load FSM states.
package biquad_pkg;

  localparam int COEFF_BITS = 18;
  localparam int COEFF_FRAC = 14;

  // Reset set makes the section a pure one-sample delay (a = 0, b = 1.0).
  localparam logic signed [COEFF_BITS-1:0] COEFF_A_RST = 18'sd0;
  localparam logic signed [COEFF_BITS-1:0] COEFF_B_RST = 18'sd16384;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HAVE_B = 2'd1,
    READY  = 2'd2
  } coeff_state_e;

endpackage

// File: rtl/biquad_zero_fir_nsamp_if.sv
// Data, bypass and coefficient-load signals of biquad_zero_fir_nsamp.
// The master modport drives stimulus; the slave modport is the filter.
interface biquad_zero_fir_nsamp_if
  import biquad_pkg::*;
#(
  parameter int NSAMP   = 8,
  parameter int NBITS   = 16,
  parameter int OUTBITS = 16,
  parameter int CBITS   = COEFF_BITS
);

  logic [NBITS*NSAMP-1:0]   dat_i;
  logic [NBITS*NSAMP-1:0]   bypass_dat_i;
  logic                     bypass_i;
  logic [CBITS-1:0]         coeff_dat_i;
  logic                     coeff_wr_i;
  logic                     coeff_update_i;
  logic                     coeff_ready_o;
  logic                     coeff_err_o;
  logic [OUTBITS*NSAMP-1:0] dat_o;

  modport master (
    output dat_i, bypass_dat_i, bypass_i, coeff_dat_i, coeff_wr_i, coeff_update_i,
    input  coeff_ready_o, coeff_err_o, dat_o
  );

  modport slave (
    input  dat_i, bypass_dat_i, bypass_i, coeff_dat_i, coeff_wr_i, coeff_update_i,
    output coeff_ready_o, coeff_err_o, dat_o
  );

endinterface

// File: rtl/biquad_zero_fir_lane.sv
// One output sample of the symmetric FIR a*(x0 + x2) + b*x1: preadd, product and
// sum/format stages. Saturation instead of wrap when BIQUAD_ZERO_FIR_SAT_EN is defined.
module biquad_zero_fir_lane
  import biquad_pkg::*;
#(
  parameter int NBITS   = 16,
  parameter int NFRAC   = 2,
  parameter int OUTBITS = 16,
  parameter int OUTFRAC = 2,
  parameter int CBITS   = COEFF_BITS,
  parameter int CFRAC   = COEFF_FRAC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [NBITS-1:0] x0,
  input  logic signed [NBITS-1:0] x1,
  input  logic signed [NBITS-1:0] x2,
  input  logic signed [CBITS-1:0] coef_a,
  input  logic signed [CBITS-1:0] coef_b,
  output logic [OUTBITS-1:0]      y
);

  localparam int PREW = NBITS + 1;
  localparam int PAW  = PREW + CBITS;
  localparam int PBW  = NBITS + CBITS;
  localparam int SUMW = NBITS + CBITS + 2;
  localparam int SH   = NFRAC + CFRAC - OUTFRAC;
  localparam int TOPW = SUMW - SH - OUTBITS + 1;

  logic signed [PREW-1:0]  pre_r;
  logic signed [NBITS-1:0] mid_r;
  logic signed [PAW-1:0]   pa_r;
  logic signed [PBW-1:0]   pb_r;
  logic signed [SUMW-1:0]  sum_s;
  logic                    unused_s;

  // R2 preadd and R3 products; both products of one beat see the same coefficients
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= {PREW{1'b0}};
      mid_r <= {NBITS{1'b0}};
      pa_r  <= {PAW{1'b0}};
      pb_r  <= {PBW{1'b0}};
    end else begin
      pre_r <= PREW'(x0) + PREW'(x2);
      mid_r <= x1;
      pa_r  <= PAW'(pre_r) * PAW'(coef_a);
      pb_r  <= PBW'(mid_r) * PBW'(coef_b);
    end
  end

  assign sum_s = SUMW'(pa_r) + SUMW'(pb_r);

`ifdef BIQUAD_ZERO_FIR_SAT_EN
  logic [TOPW-1:0] top_s;
  assign top_s    = sum_s[SUMW-1 -: TOPW];
  assign unused_s = ^sum_s[SH-1:0];

  // Clamp when the dropped upper bits are not a sign extension
  always_comb begin
    if ((&top_s) || (~|top_s)) begin
      y = sum_s[SH +: OUTBITS];
    end else if (sum_s[SUMW-1]) begin
      y = {1'b1, {(OUTBITS-1){1'b0}}};
    end else begin
      y = {1'b0, {(OUTBITS-1){1'b1}}};
    end
  end
`else
  assign unused_s = ^{sum_s[SUMW-1:SH+OUTBITS], sum_s[SH-1:0]};

  // Truncate toward minus infinity and wrap on overflow
  always_comb begin
    y = sum_s[SH +: OUTBITS];
  end
`endif

endmodule

// File: rtl/biquad_zero_fir_nsamp.sv
// NSAMP-per-clock symmetric biquad-numerator FIR with shadowed coefficient load and a
// latency-aligned bypass mux. Optional output saturation: BIQUAD_ZERO_FIR_SAT_EN.
module biquad_zero_fir_nsamp
  import biquad_pkg::*;
#(
  parameter int NSAMP   = 8,
  parameter int NBITS   = 16,
  parameter int NFRAC   = 2,
  parameter int OUTBITS = 16,
  parameter int OUTFRAC = 2,
  parameter int CBITS   = COEFF_BITS,
  parameter int CFRAC   = COEFF_FRAC
) (
  input logic                    clk,
  input logic                    rst_n,
  biquad_zero_fir_nsamp_if.slave bus
);

  localparam int DW = NBITS * NSAMP;
  localparam int OW = OUTBITS * NSAMP;

  logic [DW-1:0]          x_r;
  logic [2*NBITS-1:0]     hist_r;
  logic [DW+2*NBITS-1:0]  ext_s;
  logic [2:0][DW-1:0]     byp_dat_r;
  logic [2:0]             byp_sel_r;
  logic [OW-1:0]          y_s;
  logic [OW-1:0]          byp_conv_s;
  logic [OW-1:0]          out_s;
  logic [OW-1:0]          dat_r;
  logic signed [CBITS-1:0] a_act_r, b_act_r, a_sh_r, b_sh_r;
  coeff_state_e           state_r, state_nx_s;
  logic                   latch_a_s, latch_b_s, xfer_s, err_s;
  logic                   err_r, ready_r;

  // R1 input/history plus the bypass delay line that matches R2/R3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r       <= {DW{1'b0}};
      hist_r    <= {(2*NBITS){1'b0}};
      byp_dat_r <= {(3*DW){1'b0}};
      byp_sel_r <= 3'b000;
    end else begin
      x_r       <= bus.dat_i;
      hist_r    <= x_r[DW-1 -: 2*NBITS];
      byp_dat_r <= {byp_dat_r[1:0], bus.bypass_dat_i};
      byp_sel_r <= {byp_sel_r[1:0], bus.bypass_i};
    end
  end

  // Sample i sits at index i+2; the two oldest slots are the previous beat's tail
  assign ext_s = {x_r, hist_r};

  for (genvar i = 0; i < NSAMP; i++) begin : g_lane
    biquad_zero_fir_lane #(
      .NBITS(NBITS), .NFRAC(NFRAC), .OUTBITS(OUTBITS), .OUTFRAC(OUTFRAC),
      .CBITS(CBITS), .CFRAC(CFRAC)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .x0     (ext_s[(i+2)*NBITS +: NBITS]),
      .x1     (ext_s[(i+1)*NBITS +: NBITS]),
      .x2     (ext_s[i*NBITS +: NBITS]),
      .coef_a (a_act_r),
      .coef_b (b_act_r),
      .y      (y_s[i*OUTBITS +: OUTBITS])
    );
    assign byp_conv_s[i*OUTBITS +: OUTBITS] = OUTBITS'(signed'(byp_dat_r[2][i*NBITS +: NBITS]));
  end

  // Whole-beat select so a beat is never part filtered, part bypass
  always_comb begin
    if (byp_sel_r[2]) begin
      out_s = byp_conv_s;
    end else begin
      out_s = y_s;
    end
  end

  // R4 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat_r <= {OW{1'b0}};
    end else begin
      dat_r <= out_s;
    end
  end

  // Coefficient FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state: a write always wins over an update for the resulting state
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      EMPTY:   if (bus.coeff_wr_i) state_nx_s = HAVE_B; else state_nx_s = EMPTY;
      HAVE_B:  if (bus.coeff_wr_i) state_nx_s = READY;  else state_nx_s = HAVE_B;
      READY: begin
        if (bus.coeff_wr_i) begin
          state_nx_s = HAVE_B;
        end else if (bus.coeff_update_i) begin
          state_nx_s = EMPTY;
        end else begin
          state_nx_s = READY;
        end
      end
      default: state_nx_s = EMPTY;
    endcase
  end

  // FSM outputs, all judged against the pre-write state
  always_comb begin
    latch_a_s = 1'b0;
    latch_b_s = 1'b0;
    xfer_s    = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      EMPTY: begin
        latch_b_s = bus.coeff_wr_i;
        err_s     = bus.coeff_update_i;
      end
      HAVE_B: begin
        latch_a_s = bus.coeff_wr_i;
        err_s     = bus.coeff_update_i;
      end
      READY: begin
        latch_b_s = bus.coeff_wr_i;
        xfer_s    = bus.coeff_update_i;
      end
      default: begin
        err_s = bus.coeff_update_i;
      end
    endcase
  end

  // Shadow/active coefficients and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= {CBITS{1'b0}};
      b_sh_r  <= {CBITS{1'b0}};
      a_act_r <= CBITS'(COEFF_A_RST);
      b_act_r <= CBITS'(COEFF_B_RST);
      err_r   <= 1'b0;
      ready_r <= 1'b0;
    end else begin
      if (latch_a_s) a_sh_r <= bus.coeff_dat_i;
      if (latch_b_s) b_sh_r <= bus.coeff_dat_i;
      if (xfer_s) begin
        a_act_r <= a_sh_r;
        b_act_r <= b_sh_r;
      end
      err_r   <= err_s;
      ready_r <= (state_nx_s == READY);
    end
  end

  assign bus.dat_o         = dat_r;
  assign bus.coeff_err_o   = err_r;
  assign bus.coeff_ready_o = ready_r;

endmodule

// File: tb/tb_biquad_zero_fir_nsamp.sv
// Scoreboard bench for biquad_zero_fir_nsamp: an integer reference model predicts each
// beat at drive time; results are popped and compared four cycles later.
module tb_biquad_zero_fir_nsamp;
  import biquad_pkg::*;

  localparam int NSAMP   = 8;
  localparam int NBITS   = 16;
  localparam int OUTBITS = 16;
  localparam int CBITS   = 18;
  localparam int DW      = NSAMP * NBITS;

  typedef struct {
    logic [DW-1:0]           x;
    logic [DW-1:0]           prev;
    logic [DW-1:0]           bdat;
    logic                    byp;
    logic signed [CBITS-1:0] a;
    logic signed [CBITS-1:0] b;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  biquad_zero_fir_nsamp_if #(.NSAMP(NSAMP), .NBITS(NBITS), .OUTBITS(OUTBITS), .CBITS(CBITS)) bus ();

  biquad_zero_fir_nsamp #(
    .NSAMP(NSAMP), .NBITS(NBITS), .NFRAC(2), .OUTBITS(OUTBITS), .OUTFRAC(2),
    .CBITS(CBITS), .CFRAC(14)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  beat_t                   sb_q[$];
  int                      n_tests = 0;
  int                      n_fail  = 0;
  logic [DW-1:0]           m_prev;
  logic signed [CBITS-1:0] m_a, m_b, m_sha, m_shb;
  coeff_state_e            m_st;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // y[i] = a*(x[i]+x[i-2]) + b*x[i-1] in plain integer arithmetic, floor shift by 14
  function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] x, input logic [DW-1:0] p,
                                                input logic signed [CBITS-1:0] a,
                                                input logic signed [CBITS-1:0] b);
    logic signed [NBITS-1:0] t;
    longint v [NSAMP+2];
    longint acc, q;
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < 2; j++) begin
      t = p[(NSAMP-2+j)*NBITS +: NBITS];
      v[j] = t;
    end
    for (int i = 0; i < NSAMP; i++) begin
      t = x[i*NBITS +: NBITS];
      v[i+2] = t;
    end
    for (int i = 0; i < NSAMP; i++) begin
      acc = longint'(a) * (v[i+2] + v[i]) + longint'(b) * v[i+1];
      q = acc >>> 14;
`ifdef BIQUAD_ZERO_FIR_SAT_EN
      if (q > 64'sd32767) q = 64'sd32767;
      else if (q < -64'sd32768) q = -64'sd32768;
`endif
      r[i*OUTBITS +: OUTBITS] = q[15:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    m_prev = '0;
    m_a    = 18'sd0;
    m_b    = 18'sd16384;
    m_sha  = 18'sd0;
    m_shb  = 18'sd0;
    m_st   = EMPTY;
    sb_q.delete();
  endtask

  // One clock: drive a beat and coefficient controls, predict, then check flags and output
  task automatic step(input logic [DW-1:0] x, input logic byp, input logic [DW-1:0] bdat,
                      input logic wr, input logic [CBITS-1:0] wdat, input logic upd);
    logic  exp_err, xfer;
    beat_t e;
    bus.dat_i          = x;
    bus.bypass_i       = byp;
    bus.bypass_dat_i   = bdat;
    bus.coeff_wr_i     = wr;
    bus.coeff_dat_i    = wdat;
    bus.coeff_update_i = upd;
    exp_err = upd && (m_st != READY);
    xfer    = upd && (m_st == READY);
    if (xfer) begin
      m_a = m_sha;
      m_b = m_shb;
      // the beat presented one cycle before the update already uses the new set
      if (sb_q.size() > 0) begin
        e = sb_q[sb_q.size()-1];
        e.a = m_a;
        e.b = m_b;
        sb_q[sb_q.size()-1] = e;
      end
    end
    if (wr) begin
      if (m_st == HAVE_B) begin
        m_sha = wdat;
        m_st  = READY;
      end else begin
        m_shb = wdat;
        m_st  = HAVE_B;
      end
    end else if (xfer) begin
      m_st = EMPTY;
    end
    e.x = x; e.prev = m_prev; e.bdat = bdat; e.byp = byp; e.a = m_a; e.b = m_b;
    sb_q.push_back(e);
    m_prev = x;
    @(posedge clk);
    #1;
    check_eq("coeff_err", DW'(bus.coeff_err_o), DW'(exp_err));
    check_eq("coeff_ready", DW'(bus.coeff_ready_o), DW'(m_st == READY));
    if (sb_q.size() == 4) begin
      e = sb_q.pop_front();
      check_eq(e.byp ? "dat_o_bypass" : "dat_o_filt", bus.dat_o,
               e.byp ? e.bdat : model_beat(e.x, e.prev, e.a, e.b));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic load_coeffs(input logic [CBITS-1:0] b, input logic [CBITS-1:0] a);
    step(rnd(), 1'b0, '0, 1'b1, b, 1'b0);
    step(rnd(), 1'b0, '0, 1'b1, a, 1'b0);
    step(rnd(), 1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  // Asynchronous reset between clock edges; output must clear at once
  task automatic do_reset();
    bus.dat_i = '0; bus.bypass_i = 1'b0; bus.bypass_dat_i = '0;
    bus.coeff_wr_i = 1'b0; bus.coeff_dat_i = '0; bus.coeff_update_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_dat_o", bus.dat_o, '0);
    check_eq("rst_ready", DW'(bus.coeff_ready_o), '0);
    check_eq("rst_err", DW'(bus.coeff_err_o), '0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    do_reset();

    // reset coefficients: one-sample delay
    step(128'h4, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(5);

    // b = -1.0, a = 0.5, impulse 2.0 on sample 7
    load_coeffs(18'h3C000, 18'h02000);
    step(128'h0008 << 112, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(5);

    // lone write then update: error, set unchanged
    step(rnd(), 1'b0, '0, 1'b1, 18'h04000, 1'b0);
    step(rnd(), 1'b0, '0, 1'b0, '0, 1'b1);
    step(128'h0008 << 112, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(2);
    // second write with simultaneous update: error, then ready
    step(rnd(), 1'b0, '0, 1'b1, 18'h01000, 1'b1);
    step(rnd(), 1'b0, '0, 1'b0, '0, 1'b1);
    step(128'h0008 << 112, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(4);

    // write plus update while READY: old pair transfers, new b starts a pair
    step(rnd(), 1'b0, '0, 1'b1, 18'h02000, 1'b0);
    step(rnd(), 1'b0, '0, 1'b1, 18'h00800, 1'b0);
    step(rnd(), 1'b0, '0, 1'b1, 18'h3F000, 1'b1);
    step(rnd(), 1'b0, '0, 1'b1, 18'h00400, 1'b0);
    step(rnd(), 1'b0, '0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) step(rnd(), 1'b0, '0, 1'b0, '0, 1'b0);
    idle(4);

    // overflow: b = 2.0, a = 0, full-scale positive input
    load_coeffs(18'h08000, 18'h00000);
    for (int k = 0; k < 6; k++) step({8{16'h7FFC}}, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(4);

    // bypass window of three beats inside filtered traffic
    load_coeffs(18'h3C000, 18'h02000);
    step(rnd(), 1'b0, '0, 1'b0, '0, 1'b0);
    step(rnd(), 1'b0, '0, 1'b0, '0, 1'b0);
    step(rnd(), 1'b1, {8{16'hA5A5}}, 1'b0, '0, 1'b0);
    step(rnd(), 1'b1, {8{16'h1234}}, 1'b0, '0, 1'b0);
    step(rnd(), 1'b1, {8{16'h8001}}, 1'b0, '0, 1'b0);
    step(rnd(), 1'b0, {8{16'hFFFF}}, 1'b0, '0, 1'b0);
    step(rnd(), 1'b0, '0, 1'b0, '0, 1'b0);
    idle(4);

    // reset in HAVE_B while filtering
    step(rnd(), 1'b0, '0, 1'b1, 18'h02000, 1'b0);
    step(rnd(), 1'b0, '0, 1'b0, '0, 1'b0);
    do_reset();
    step(128'h4, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(5);
    // one write after reset must leave the FSM in HAVE_B, not READY
    step(rnd(), 1'b0, '0, 1'b1, 18'h02000, 1'b0);
    step(rnd(), 1'b0, '0, 1'b0, '0, 1'b1);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/biquad_zero_fir_nsamp.md
# biquad_zero_fir_nsamp

Parametrised symmetric second-order FIR (biquad numerator, a + b·z⁻¹ + a·z⁻²) for NSAMP samples per clock. It sits after the IIR pole section and owns the filter/bypass output mux. Each output beat is computed entirely from one coefficient set. Coefficients are loaded through a sequenced shadow register and a checked update. The bypass switch is latency-aligned so no output beat mixes filtered and bypass data.

## Interface
- NSAMP, 8, samples per clock (≥2)
- NBITS, 16, input sample width, signed Q(NBITS-NFRAC).NFRAC
- NFRAC, 2, input fractional bits
- OUTBITS, 16, output sample width
- OUTFRAC, 2, output fractional bits
- CBITS, 18, coefficient width, signed
- CFRAC, 14, coefficient fractional bits (Q4.14)
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- dat_i  in  NBITS·NSAMP  filter input; sample 0 is earliest in time
- bypass_dat_i  in  NBITS·NSAMP  bypass data, same format as dat_i
- bypass_i  in  1  select bypass for the beat presented this cycle
- coeff_dat_i  in  CBITS  coefficient write data
- coeff_wr_i  in  1  coefficient write strobe
- coeff_update_i  in  1  shadow→active transfer request
- coeff_ready_o  out  1  shadow holds a complete (b, a) pair
- coeff_err_o  out  1  one-cycle pulse: update requested while not ready
- dat_o  out  OUTBITS·NSAMP  output, Q(OUTBITS-OUTFRAC).OUTFRAC

## Operation
- Sample i output is y[i] = a·(x[i] + x[i-2]) + b·x[i-1]. Indices below 0 use the previous beat's samples NSAMP-2 and NSAMP-1, held in a history register.
- Arithmetic, with no intermediate loss:
  - the preadd is NBITS+1 bits;
  - the products are NBITS+1+CBITS and NBITS+CBITS bits;
  - the sum is NBITS+CBITS+2 bits with NFRAC+CFRAC fractional bits.
- Output is taken from the sum starting at bit NFRAC+CFRAC-OUTFRAC. This is truncation toward −∞. Overflow handling is set by the macro described under Configuration.
- Coefficient FSM states: EMPTY, HAVE_B, READY.
  - Write in EMPTY: latch b_shadow, go to HAVE_B.
  - Write in HAVE_B: latch a_shadow, go to READY.
  - Write in READY: latch b_shadow, go to HAVE_B (restarts the pair).
  - Update in READY: active ← shadow, go to EMPTY.
  - Update in EMPTY or HAVE_B: ignored, coeff_err_o pulses.
- Simultaneous write and update: the update is evaluated against the pre-write state first, then the write applies.
  - In READY: transfer occurs, then b_shadow is latched and the FSM goes to HAVE_B.
  - In HAVE_B: coeff_err_o pulses, a_shadow is latched and the FSM goes to READY.
- coeff_ready_o = (state == READY), registered.
- Bypass: bypass_dat_i and bypass_i travel through a delay line equal to the filter latency. The output register selects per beat.

## Timing
- Latency is 4 cycles. A beat presented in cycle t appears on dat_o in cycle t+4. The same holds for bypass_dat_i/bypass_i.
- Pipeline stages:
  - R1: input and history register.
  - R2: preadd.
  - R3: products, using the active coefficients.
  - R4: sum, format, bypass mux, output register.
- Coefficient update asserted in cycle u makes the new active set visible from u+1. The first beat filtered with the new set is the one presented in cycle u-1; it appears on dat_o in cycle u+3. Every beat uses exactly one set.
- coeff_err_o pulses in cycle u+1.
- Reset (asynchronous, any time, including mid-load) forces:
  - dat_o = 0, coeff_err_o = 0, coeff_ready_o = 0;
  - all pipeline, history and bypass registers = 0;
  - FSM = EMPTY, shadow = 0;
  - active a = 0, active b = 1.0 (1 << CFRAC), so the filter resets to a one-sample delay.
- Operation resumes on the first clock edge after rst_n rises.

## Configuration
- BIQUAD_ZERO_FIR_SAT_EN defined: output saturates to the most positive/negative OUTBITS value when the discarded upper sum bits are not a sign extension.
- Not defined: the upper bits are dropped (wrap).
- Bypass data is never altered in either case.

## Structure
- Package biquad_pkg holds:
  - the coefficient width/fraction constants (CBITS = 18, CFRAC = 14);
  - the reset coefficient values;
  - the typedef enum for the FSM (EMPTY, HAVE_B, READY).
- One sub-module, biquad_zero_fir_lane, is instantiated NSAMP times. It takes x[i], x[i-1], x[i-2], a and b, and contains R2 through the R4 format stage.
- The top level holds R1/history, the FSM, the active/shadow registers, the bypass delay line and the mux.

## Test plan
All scenarios use the default parameters.
- After reset with no writes, apply dat_i sample 0 = 0x0004 (1.0), all others 0, in cycle k → dat_o sample 1 = 0x0004 in cycle k+4; all other samples 0.
- Write b = 0x3C000 (−1.0), then a = 0x02000 (0.5), then update. Impulse 0x0008 on sample 7 → outputs, in order:
  - sample 7 = 0x0004;
  - next beat sample 0 = 0xFFF8;
  - next beat sample 1 = 0x0004.
- Single write then update → coeff_err_o one-cycle pulse, coeff_ready_o stays 0, impulse response unchanged. Second write plus simultaneous update → err pulse, ready = 1.
- a = 0, b = 0x08000 (2.0), all samples 0x7FFC → dat_o all 0x7FFF with BIQUAD_ZERO_FIR_SAT_EN defined; all 0xFFF8 without it.
- Set bypass_i = 1 for cycles t..t+2 with a distinct bypass pattern → dat_o equals that pattern in cycles t+4..t+6 and filtered data otherwise, with no mixed beat.
- Deassert rst_n mid-load in the HAVE_B state while filtering → dat_o = 0 immediately. After release, the FSM is in EMPTY and the impulse test matches the first scenario.
